sega6_pad_responder: RTL and testbench



---
 rtl/sega_pad_pkg.sv | 47 ++++
 rtl/sega6_pad_responder_sel_sync.sv | 24 ++
 rtl/sega6_pad_responder.sv | 83 ++++++++
 tb/tb_sega6_pad_responder.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/sega_pad_pkg.sv
// Shared definitions for the Mega Drive pad responder: button bit positions,
// the phase type and the select/phase to DB9 pin mapping.
package sega_pad_pkg;

  localparam int BTN_U     = 0;
  localparam int BTN_D     = 1;
  localparam int BTN_L     = 2;
  localparam int BTN_R     = 3;
  localparam int BTN_B     = 4;
  localparam int BTN_C     = 5;
  localparam int BTN_A     = 6;
  localparam int BTN_START = 7;
  localparam int BTN_Z     = 8;
  localparam int BTN_Y     = 9;
  localparam int BTN_X     = 10;
  localparam int BTN_MODE  = 11;

  localparam int DEFAULT_TIMEOUT = 36000;

  typedef logic [2:0] phase_t;

  // Returns {up, down, left, right, p6, p9}, all active-low like the buttons.
  function automatic logic [5:0] pad_map(input logic       sel_level,
                                         input phase_t     cnt,
                                         input logic [11:0] btn_n,
                                         input logic       six_button);
    logic       ext_phase;
    logic [5:0] pins;
    ext_phase = six_button && (cnt == 3'd3);
    if (sel_level) begin
      if (ext_phase)
        pins = {btn_n[BTN_Z], btn_n[BTN_Y], btn_n[BTN_X], btn_n[BTN_MODE],
                btn_n[BTN_B], btn_n[BTN_C]};
      else
        pins = {btn_n[BTN_U], btn_n[BTN_D], btn_n[BTN_L], btn_n[BTN_R],
                btn_n[BTN_B], btn_n[BTN_C]};
    end else if (cnt == 3'd4) begin
      pins = {4'b1111, btn_n[BTN_A], btn_n[BTN_START]};
    end else if (ext_phase) begin
      pins = {4'b0000, btn_n[BTN_A], btn_n[BTN_START]};
    end else begin
      pins = {btn_n[BTN_U], btn_n[BTN_D], 2'b00, btn_n[BTN_A], btn_n[BTN_START]};
    end
    return pins;
  endfunction

endpackage

// File: rtl/sega6_pad_responder_sel_sync.sv
// Two-stage synchroniser for the select line plus a falling-edge pulse that is
// aligned with the synchronised level, so both change the state on one edge.
module sel_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic sel_async,
  output logic sel_level,
  output logic sel_fall
);

  // [0],[1] form the synchroniser; [2] remembers the previous synchronised level.
  logic [2:0] stage_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stage_reg <= 3'b111;
    else
      stage_reg <= {stage_reg[1:0], sel_async};
  end

  assign sel_level = stage_reg[1];
  assign sel_fall  = stage_reg[2] & ~stage_reg[1];

endmodule

// File: rtl/sega6_pad_responder.sv
// Mega Drive 6-button pad emulation: phase counter driven by select falling
// edges, an inactivity timeout, and a registered pin multiplexer.
module sega6_pad_responder
  import sega_pad_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int SIX_BUTTON     = 1
) (
  input  logic        clk_i,
  input  logic        res_n_i,
  input  logic        select_i,
  input  logic [11:0] buttons_n_i,
  output logic        pad_up_o,
  output logic        pad_down_o,
  output logic        pad_left_o,
  output logic        pad_right_o,
  output logic        pad_p6_o,
  output logic        pad_p9_o,
  output logic [2:0]  phase_o,
  output logic        timeout_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          sel_level;
  logic          sel_fall;
  logic          timeout_hit;
  phase_t        cnt_reg, cnt_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [5:0]    pins_reg, pins_next;
  logic          timeout_reg, timeout_next;

  sel_sync u_sel_sync (
    .clk       (clk_i),
    .rst_n     (res_n_i),
    .sel_async (select_i),
    .sel_level (sel_level),
    .sel_fall  (sel_fall)
  );

  always_comb begin
    cnt_next     = cnt_reg;
    timer_next   = timer_reg;
    timeout_next = 1'b0;
    timeout_hit  = (timer_reg == TW'(TIMEOUT_CYCLES - 1)) && (cnt_reg != 3'd0);
    if (sel_fall) begin
      timer_next = '0;
      // An edge landing on the timeout cycle starts a fresh frame at phase 1.
      if (timeout_hit || cnt_reg == 3'd4)
        cnt_next = 3'd1;
      else
        cnt_next = cnt_reg + 3'd1;
    end else begin
      if (timer_reg != TW'(TIMEOUT_CYCLES))
        timer_next = timer_reg + TW'(1);
      if (timeout_hit) begin
        cnt_next     = 3'd0;
        timeout_next = 1'b1;
      end
    end
    // Mux from next-state values so pins and phase_o move on the same edge.
    pins_next = pad_map(sel_level, cnt_next, buttons_n_i, SIX_BUTTON != 0);
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      cnt_reg     <= 3'd0;
      timer_reg   <= '0;
      pins_reg    <= 6'b111111;
      timeout_reg <= 1'b0;
    end else begin
      cnt_reg     <= cnt_next;
      timer_reg   <= timer_next;
      pins_reg    <= pins_next;
      timeout_reg <= timeout_next;
    end
  end

  assign {pad_up_o, pad_down_o, pad_left_o, pad_right_o, pad_p6_o, pad_p9_o} = pins_reg;
  assign phase_o   = cnt_reg;
  assign timeout_o = timeout_reg;

endmodule

// File: tb/tb_sega6_pad_responder.sv
// Randomised and directed bench for the pad responder; a 6-button and a
// 3-button instance share stimulus and are checked against a frame-level model.
module tb_sega6_pad_responder;

  localparam int T = 200;

  logic        clk = 1'b0;
  logic        res_n_i = 1'b0;
  logic        select_i = 1'b1;
  logic [11:0] buttons_n_i = 12'hFFF;

  logic a_up, a_dn, a_lf, a_rt, a_p6, a_p9, a_to;
  logic b_up, b_dn, b_lf, b_rt, b_p6, b_p9, b_to;
  logic [2:0] a_ph, b_ph;

  always #5 clk = ~clk;

  sega6_pad_responder #(.TIMEOUT_CYCLES(T), .SIX_BUTTON(1)) u_six (
    .clk_i(clk), .res_n_i(res_n_i), .select_i(select_i), .buttons_n_i(buttons_n_i),
    .pad_up_o(a_up), .pad_down_o(a_dn), .pad_left_o(a_lf), .pad_right_o(a_rt),
    .pad_p6_o(a_p6), .pad_p9_o(a_p9), .phase_o(a_ph), .timeout_o(a_to));

  sega6_pad_responder #(.TIMEOUT_CYCLES(T), .SIX_BUTTON(0)) u_three (
    .clk_i(clk), .res_n_i(res_n_i), .select_i(select_i), .buttons_n_i(buttons_n_i),
    .pad_up_o(b_up), .pad_down_o(b_dn), .pad_left_o(b_lf), .pad_right_o(b_rt),
    .pad_p6_o(b_p6), .pad_p9_o(b_p9), .phase_o(b_ph), .timeout_o(b_to));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Frame-level model: select seen two clocks late, phase = falling edges mod 4.
  int         m_cnt, m_since, to_seen;
  bit         m_to;
  bit         sel_q[$];
  logic [5:0] m_pins6, m_pins3;
  bit         rst_drive;

  function automatic logic [5:0] ref_pins(bit s, int c, logic [11:0] b, bit six);
    logic u, d, l, r, bb, cc, a, st, z, y, x, m;
    {m, x, y, z, st, a, cc, bb, r, l, d, u} = b;
    if (s) return (six && c == 3) ? {z, y, x, m, bb, cc} : {u, d, l, r, bb, cc};
    if (c == 4) return {4'hF, a, st};
    if (six && c == 3) return {4'h0, a, st};
    return {u, d, 2'b00, a, st};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_since = 0; m_to = 0;
    m_pins6 = 6'h3F; m_pins3 = 6'h3F;
    sel_q.delete();
    repeat (3) sel_q.push_back(1'b1);
  endtask

  task automatic step(input string tag, input bit s_in, input logic [11:0] b_in);
    bit lvl, prev, fall, hit;
    @(negedge clk);
    res_n_i = rst_drive; select_i = s_in; buttons_n_i = b_in;
    @(posedge clk);
    if (!res_n_i) begin
      model_reset();
    end else begin
      sel_q.push_back(s_in);
      if (sel_q.size() > 4) void'(sel_q.pop_front());
      lvl  = sel_q[sel_q.size() - 3];
      prev = sel_q[sel_q.size() - 4];
      fall = prev && !lvl;
      hit  = (m_since == T - 1) && (m_cnt != 0);
      m_to = 0;
      if (fall) begin
        m_cnt = hit ? 1 : (m_cnt % 4) + 1;
        m_since = 0;
      end else begin
        if (hit) begin m_cnt = 0; m_to = 1; end
        if (m_since < T) m_since++;
      end
      m_pins6 = ref_pins(lvl, m_cnt, b_in, 1'b1);
      m_pins3 = ref_pins(lvl, m_cnt, b_in, 1'b0);
    end
    #1;
    if (a_to) to_seen++;
    check({tag, "_six"}, 16'({a_up, a_dn, a_lf, a_rt, a_p6, a_p9, a_ph, a_to}),
          16'({m_pins6, 3'(m_cnt), m_to}));
    check({tag, "_three"}, 16'({b_up, b_dn, b_lf, b_rt, b_p6, b_p9, b_ph, b_to}),
          16'({m_pins3, 3'(m_cnt), m_to}));
  endtask

  task automatic pulses(input string tag, input int n, input int len, input logic [11:0] b);
    for (int i = 0; i < n; i++) begin
      repeat (len) step(tag, 1'b0, b);
      repeat (len) step(tag, 1'b1, b);
    end
  endtask

  initial begin
    model_reset();
    rst_drive = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_six", 16'({a_up, a_dn, a_lf, a_rt, a_p6, a_p9, a_ph, a_to}), 16'h3F0);
    check("reset_three", 16'({b_up, b_dn, b_lf, b_rt, b_p6, b_p9, b_ph, b_to}), 16'h3F0);
    $display("txn reset checks=%0d errors=%0d", checks, errors);

    rst_drive = 1;
    step("idle", 1'b1, 12'hFFF);
    step("press_u", 1'b1, 12'hFFE);
    check("press_u_pin", 16'(a_up), 16'h0);
    repeat (3) step("press_u", 1'b1, 12'hFFE);
    $display("txn press_u checks=%0d errors=%0d", checks, errors);

    pulses("frame", 4, 48, 12'hE5A);
    repeat (T + 10) step("frame_idle", 1'b1, 12'hE5A);
    $display("txn frame_e5a checks=%0d errors=%0d", checks, errors);

    pulses("two", 2, 10, 12'h3C5);
    to_seen = 0;
    repeat (T + 10) step("two_idle", 1'b1, 12'h3C5);
    check("timeout_count", 16'(to_seen), 16'd1);
    check("timeout_phase", 16'(a_ph), 16'd0);
    pulses("after_to", 1, 10, 12'h3C5);
    repeat (T + 10) step("after_to_idle", 1'b1, 12'h3C5);
    $display("txn timeout checks=%0d errors=%0d", checks, errors);

    pulses("five", 5, 6, 12'hA5F);
    repeat (T + 10) step("five_idle", 1'b1, 12'hA5F);
    $display("txn five_edges checks=%0d errors=%0d", checks, errors);

    // Second low starts exactly T clocks after the first: edge meets the timeout.
    for (int d = T - 1; d <= T + 1; d++) begin
      repeat (5) step("edge_at_to", 1'b0, 12'h9B6);
      repeat (d - 5) step("edge_at_to", 1'b1, 12'h9B6);
      repeat (5) step("edge_at_to", 1'b0, 12'h9B6);
      repeat (T + 10) step("edge_at_to_idle", 1'b1, 12'h9B6);
    end
    $display("txn edge_at_timeout checks=%0d errors=%0d", checks, errors);

    pulses("pre_rst", 2, 6, 12'h6C3);
    repeat (6) step("pre_rst", 1'b0, 12'h6C3);
    check("pre_rst_phase", 16'(a_ph), 16'd3);
    #2;
    rst_drive = 0; res_n_i = 1'b0;
    #1;
    check("async_rst_six", 16'({a_up, a_dn, a_lf, a_rt, a_p6, a_p9, a_ph, a_to}), 16'h3F0);
    check("async_rst_three", 16'({b_up, b_dn, b_lf, b_rt, b_p6, b_p9, b_ph, b_to}), 16'h3F0);
    model_reset();
    repeat (2) step("in_rst", 1'b0, 12'h6C3);
    rst_drive = 1;
    repeat (4) step("post_rst", 1'b1, 12'h6C3);
    pulses("post_rst", 4, 20, 12'h6C3);
    repeat (T + 10) step("post_rst_idle", 1'b1, 12'h6C3);
    $display("txn async_reset checks=%0d errors=%0d", checks, errors);

    for (int f = 0; f < 8; f++) begin
      for (int p = 0; p < 4 + int'($urandom_range(0, 1)); p++) begin
        repeat ($urandom_range(1, 40)) step("rand", 1'b0, 12'($urandom));
        repeat ($urandom_range(1, 40)) step("rand", 1'b1, 12'($urandom));
      end
      repeat ($urandom_range(T - 20, T + 20)) step("rand_idle", 1'b1, 12'($urandom));
      $display("txn random_frame %0d checks=%0d errors=%0d", f, checks, errors);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
